// File: rtl/extract_field_multi.sv
// ----------------------------------------------------------------------------
// extract_field_multi
//
// Runtime-configurable, multi-channel field extractor. Each accepted PHV is
// split into EXTRACT_WIDTH-bit units (unit 0 is the MSB unit). Every channel
// pulls a field of up to MAX_UNITS consecutive units, starting at its
// programmed unit offset. The results are left-aligned in the channel slice
// and zero-padded at the LSB end. They then go to a single registered
// valid/ready output stage.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid/o_ready  PHV input handshake (o_ready = ~o_valid | i_ready)
//   i_data           PHV, unit 0 = i_data[PHV_WIDTH-1 -: EXTRACT_WIDTH]
//   o_valid/i_ready  result output handshake
//   o_extract_data   channel c at [c*MAX_UNITS*EXTRACT_WIDTH +: MAX_UNITS*EXTRACT_WIDTH]
//   o_err            per-channel out-of-range flag, qualified by o_valid
//   i_cfg_*          control-plane write of one channel's offset/length
// ----------------------------------------------------------------------------
module extract_field_multi #(
    parameter int PHV_WIDTH     = 1024,
    parameter int EXTRACT_WIDTH = 8,
    parameter int NUM_CH        = 4,
    parameter int MAX_UNITS     = 4,
    parameter int UNITS         = PHV_WIDTH / EXTRACT_WIDTH,
    parameter int OFFSET_WIDTH  = $clog2(UNITS),
    parameter int LEN_WIDTH     = $clog2(MAX_UNITS + 1),
    parameter int CH_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [PHV_WIDTH-1:0]                      i_data,
    output logic                                      o_valid,
    input  logic                                      i_ready,
    output logic [NUM_CH*MAX_UNITS*EXTRACT_WIDTH-1:0] o_extract_data,
    output logic [NUM_CH-1:0]                         o_err,
    input  logic                                      i_cfg_wr,
    input  logic [CH_WIDTH-1:0]                       i_cfg_ch,
    input  logic [OFFSET_WIDTH-1:0]                   i_cfg_offset,
    input  logic [LEN_WIDTH-1:0]                      i_cfg_len
);

    localparam int CH_DW = MAX_UNITS * EXTRACT_WIDTH;
    // The sum width must hold off+len without wrapping. It must also be wide enough for UNITS.
    localparam int SUM_W = ((OFFSET_WIDTH > LEN_WIDTH) ? OFFSET_WIDTH : LEN_WIDTH) + 1;

    logic [OFFSET_WIDTH-1:0]          cfg_off [NUM_CH];
    logic [LEN_WIDTH-1:0]             cfg_len [NUM_CH];
    logic [EXTRACT_WIDTH-1:0]         phv_units [UNITS];
    logic [NUM_CH*CH_DW-1:0]          next_data;
    logic [NUM_CH-1:0]                next_err;
    logic                             accept;

    assign o_ready = ~o_valid | i_ready;
    assign accept  = i_valid & o_ready;

    for (genvar u = 0; u < UNITS; u++) begin : g_units
        assign phv_units[u] = i_data[PHV_WIDTH-1-u*EXTRACT_WIDTH -: EXTRACT_WIDTH];
    end

    // Config register file. Writes to channels that do not exist are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cfg_off[c] <= '0;
                cfg_len[c] <= '0;
            end
        end else if (i_cfg_wr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(i_cfg_ch) == c) begin
                    cfg_off[c] <= i_cfg_offset;
                    cfg_len[c] <= i_cfg_len;
                end
            end
        end
    end

    // The extraction reads the config values that are registered now. A config write
    // on the same edge as an acceptance therefore only affects the following PHV.
    always_comb begin
        next_data = '0;
        next_err  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [LEN_WIDTH-1:0]     len_eff;
            logic [SUM_W-1:0]         end_unit;
            logic [SUM_W-1:0]         idx;
            logic [EXTRACT_WIDTH-1:0] unit;

            len_eff  = (cfg_len[c] > LEN_WIDTH'(MAX_UNITS)) ? LEN_WIDTH'(MAX_UNITS) : cfg_len[c];
            end_unit = SUM_W'(cfg_off[c]) + SUM_W'(cfg_len[c]);
            next_err[c] = (end_unit > SUM_W'(UNITS)) || (cfg_len[c] > LEN_WIDTH'(MAX_UNITS));

            for (int k = 0; k < MAX_UNITS; k++) begin
                idx  = SUM_W'(cfg_off[c]) + SUM_W'(k);
                unit = '0;
                if ((LEN_WIDTH'(k) < len_eff) && (idx < SUM_W'(UNITS))) begin
                    unit = phv_units[idx[OFFSET_WIDTH-1:0]];
                end
                // Unit k sits at the MSB end of the channel slice. This keeps fields left-aligned.
                next_data[c*CH_DW + (MAX_UNITS-1-k)*EXTRACT_WIDTH +: EXTRACT_WIDTH] = unit;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_extract_data <= '0;
            o_err          <= '0;
        end else if (accept) begin
            o_valid        <= 1'b1;
            o_extract_data <= next_data;
            o_err          <= next_err;
        end else if (i_ready) begin
            o_valid        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_extract_field_multi.sv
module tb_extract_field_multi;

    localparam int PW = 64;
    localparam int EW = 8;
    localparam int NC = 2;
    localparam int MU = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready_o, ovalid, ready_i;
    logic [63:0] data;
    logic [31:0] xdata;
    logic [1:0]  err;
    logic        cfg_wr;
    logic [0:0]  cfg_ch;
    logic [2:0]  cfg_off;
    logic [1:0]  cfg_len;

    // single-channel build, used for the out-of-range channel write
    logic        valid2, ready2_o, ovalid2;
    logic [15:0] xdata2;
    logic [0:0]  err2;
    logic        cfg_wr2;
    logic [0:0]  cfg_ch2;
    logic [2:0]  cfg_off2;
    logic [1:0]  cfg_len2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    extract_field_multi #(.PHV_WIDTH(PW), .EXTRACT_WIDTH(EW), .NUM_CH(NC), .MAX_UNITS(MU)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_o), .i_data(data),
        .o_valid(ovalid), .i_ready(ready_i), .o_extract_data(xdata), .o_err(err),
        .i_cfg_wr(cfg_wr), .i_cfg_ch(cfg_ch), .i_cfg_offset(cfg_off), .i_cfg_len(cfg_len));

    extract_field_multi #(.PHV_WIDTH(PW), .EXTRACT_WIDTH(EW), .NUM_CH(1), .MAX_UNITS(MU)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(ready2_o), .i_data(data),
        .o_valid(ovalid2), .i_ready(1'b1), .o_extract_data(xdata2), .o_err(err2),
        .i_cfg_wr(cfg_wr2), .i_cfg_ch(cfg_ch2), .i_cfg_offset(cfg_off2), .i_cfg_len(cfg_len2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic ch, input logic [2:0] off, input logic [1:0] len);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_off = off; cfg_len = len;
        tick();
        cfg_wr = 1'b0;
    endtask

    localparam logic [63:0] BASE = 64'h0011_2233_4455_6677;
    localparam logic [63:0] INC  = 64'h0101_0101_0101_0101;

    // ch0 off2 len2 -> {u2,u3}; ch1 off1 len3 (clamped to 2) -> {u1,u2}; data = BASE + n*INC
    logic [31:0] exp_stream [4] = '{32'h1122_2233, 32'h1223_2334, 32'h1324_2435, 32'h1425_2536};

    initial begin
        rst_n = 1'b0; valid = 1'b0; ready_i = 1'b1; data = BASE;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_off = '0; cfg_len = '0;
        valid2 = 1'b0; cfg_wr2 = 1'b0; cfg_ch2 = '0; cfg_off2 = '0; cfg_len2 = '0;
        #1;
        chk("rst_valid", 64'(ovalid), 64'd0);
        chk("rst_err",   64'(err),    64'd0);
        chk("rst_data",  64'(xdata),  64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // first PHV with no configuration written
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("noconf_valid", 64'(ovalid), 64'd1);
        chk("noconf_data",  64'(xdata),  64'd0);
        chk("noconf_err",   64'(err),    64'd0);
        tick();
        chk("drop_valid", 64'(ovalid), 64'd0);

        // basic extraction
        cfg(1'b0, 3'd2, 2'd2);
        cfg(1'b1, 3'd5, 2'd1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("basic_valid", 64'(ovalid), 64'd1);
        chk("basic_data",  64'(xdata),  64'h5500_2233);
        chk("basic_err",   64'(err),    64'd0);

        // field runs past end of PHV
        cfg(1'b1, 3'd7, 2'd2);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("oor_data", 64'(xdata), 64'h7700_2233);
        chk("oor_err",  64'(err),   64'b10);

        // length above MAX_UNITS at the end of the PHV
        cfg(1'b1, 3'd7, 2'd3);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("clamp_end_data", 64'(xdata), 64'h7700_2233);
        chk("clamp_end_err",  64'(err),   64'b10);

        // length above MAX_UNITS, in range otherwise
        cfg(1'b1, 3'd1, 2'd3);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("clamp_data", 64'(xdata), 64'h1122_2233);
        chk("clamp_err",  64'(err),   64'b10);
        tick();

        // back-to-back stream
        for (int n = 0; n < 4; n++) begin
            valid = 1'b1;
            data  = BASE + 64'(n) * INC;
            tick();
            chk($sformatf("stream%0d_valid", n), 64'(ovalid), 64'd1);
            chk($sformatf("stream%0d_data", n),  64'(xdata),  64'(exp_stream[n]));
        end
        valid = 1'b0;
        tick();
        chk("stream_end_valid", 64'(ovalid), 64'd0);

        // backpressure mid-stream
        valid = 1'b1; data = BASE;
        tick();
        chk("bp_first", 64'(xdata), 64'(exp_stream[0]));
        data = BASE + INC; ready_i = 1'b0;
        #1;
        chk("bp_ready_low", 64'(ready_o), 64'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", n), 64'(ovalid), 64'd1);
            chk($sformatf("bp_hold%0d_data", n),  64'(xdata),  64'(exp_stream[0]));
        end
        ready_i = 1'b1;
        #1;
        chk("bp_ready_high", 64'(ready_o), 64'd1);
        tick();
        chk("bp_second", 64'(xdata), 64'(exp_stream[1]));
        data = BASE + 2 * INC;
        tick();
        chk("bp_third", 64'(xdata), 64'(exp_stream[2]));
        valid = 1'b0;
        tick();
        chk("bp_end_valid", 64'(ovalid), 64'd0);

        // config write in the same cycle as acceptance
        data = BASE; valid = 1'b1;
        cfg(1'b0, 3'd0, 2'd2);
        chk("samecyc_old", 64'(xdata[15:0]), 64'h2233);
        tick();
        valid = 1'b0;
        chk("samecyc_new", 64'(xdata[15:0]), 64'h0011);

        // reset while a result is held
        ready_i = 1'b0; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("held_valid", 64'(ovalid), 64'd1);
        chk("held_err",   64'(err),    64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ovalid), 64'd0);
        chk("midrst_data",  64'(xdata),  64'd0);
        chk("midrst_err",   64'(err),    64'd0);
        tick();
        rst_n = 1'b1; ready_i = 1'b1;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("postrst_valid", 64'(ovalid), 64'd1);
        chk("postrst_data",  64'(xdata),  64'd0);
        chk("postrst_err",   64'(err),    64'd0);

        // single-channel build: a write to channel 1 must be dropped
        cfg_wr2 = 1'b1; cfg_ch2 = 1'b1; cfg_off2 = 3'd2; cfg_len2 = 2'd2;
        tick();
        cfg_wr2 = 1'b0;
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        chk("nc1_bad_valid", 64'(ovalid2), 64'd1);
        chk("nc1_bad_data",  64'(xdata2),  64'd0);
        cfg_wr2 = 1'b1; cfg_ch2 = 1'b0; cfg_off2 = 3'd6; cfg_len2 = 2'd2;
        tick();
        cfg_wr2 = 1'b0;
        valid2 = 1'b1;
        tick();
        valid2 = 1'b0;
        chk("nc1_good_data", 64'(xdata2), 64'h6677);
        chk("nc1_good_err",  64'(err2),   64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/extract_field_multi.md
Name: extract_field_multi

Overview:
Multi-channel, runtime-configurable field extractor for the 3-stage parser. It accepts one PHV per handshake. In parallel, for NUM_CH channels, it pulls a field of 1..MAX_UNITS consecutive EXTRACT_WIDTH-bit units from a per-channel programmable unit offset. Results go to a registered valid/ready output stage with backpressure. Offsets and lengths are held in internal config registers written by the control plane. Out-of-range fields are flagged per channel.

Parameters:
PHV_WIDTH, 1024, input PHV width in bits; must be a multiple of EXTRACT_WIDTH.
EXTRACT_WIDTH, 8, unit width in bits.
NUM_CH, 4, number of parallel extraction channels.
MAX_UNITS, 4, maximum field length in units per channel.
UNITS, PHV_WIDTH/EXTRACT_WIDTH, derived; number of units in the PHV.
OFFSET_WIDTH, $clog2(UNITS), derived.
LEN_WIDTH, $clog2(MAX_UNITS+1), derived.
CH_WIDTH, max(1,$clog2(NUM_CH)), derived.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  PHV valid
o_ready  out  1  block can accept a PHV
i_data  in  PHV_WIDTH  PHV; unit 0 = i_data[PHV_WIDTH-1 -: EXTRACT_WIDTH]
o_valid  out  1  extracted result valid
i_ready  in  1  downstream accepts result
o_extract_data  out  NUM_CH*MAX_UNITS*EXTRACT_WIDTH  channel c in slice [c*MAX_UNITS*EXTRACT_WIDTH +: MAX_UNITS*EXTRACT_WIDTH]
o_err  out  NUM_CH  per-channel out-of-range flag, qualified by o_valid
i_cfg_wr  in  1  config write strobe
i_cfg_ch  in  CH_WIDTH  channel to write
i_cfg_offset  in  OFFSET_WIDTH  start unit
i_cfg_len  in  LEN_WIDTH  field length in units

Behaviour:
- Clock i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_valid=0, o_extract_data=0, o_err=0. All channel offsets=0 and lengths=0.
- Input handshake:
  - o_ready = ~o_valid | i_ready (combinational).
  - A PHV is accepted when i_valid & o_ready.
- Latency: exactly 1 cycle from acceptance to o_valid=1. Full throughput of one PHV per cycle while i_ready=1.
- Output hold: while o_valid & ~i_ready, o_extract_data and o_err stay stable and no PHV is accepted.
- o_valid rules:
  - o_valid drops to 0 after an output handshake with no new acceptance in the same cycle.
  - Simultaneous output handshake and input acceptance: o_valid stays 1 and new data loads.
- Extraction for channel c with offset off and length len. For k in 0..MAX_UNITS-1, output unit k is:
  - PHV unit (off+k) if k < len and off+k < UNITS;
  - zero otherwise.
- Output unit 0 is the MSB unit of the channel slice, so fields are left-aligned and zero-padded at the LSB end.
- o_err[c] = 1 when either holds:
  - off+len > UNITS (computed without wrap, width OFFSET_WIDTH+1);
  - len > MAX_UNITS, in which case len is clamped to MAX_UNITS.
- len = 0 gives a zero field with o_err = 0.
- Config writes:
  - When i_cfg_wr=1, the registers of channel i_cfg_ch update at the clock edge.
  - A write to i_cfg_ch >= NUM_CH is ignored.
  - Config registers are sampled at PHV acceptance. A write in the same cycle as acceptance does not affect that PHV; it affects the next one.
- Reset mid-operation: all state, including config, is cleared immediately. Any in-flight result is discarded.
- No combinational path from i_data or i_cfg_* to outputs. The only combinational output path is i_ready -> o_ready.

Test Plan:
All scenarios use PHV_WIDTH=64, EXTRACT_WIDTH=8, NUM_CH=2, MAX_UNITS=2, i_data=0x0011223344556677 unless stated.

- Reset → o_valid=0, o_err=0, o_extract_data=0. First PHV with no config writes → o_extract_data=0, o_err=0.
- Config ch0 off=2 len=2, ch1 off=5 len=1. Accept PHV → 1 cycle later o_valid=1, ch0=0x2233, ch1=0x5500, o_err=2'b00.
- Config ch1 off=7 len=2 → ch1=0x7700, o_err=2'b10. Config ch1 len=3 → clamped, o_err[1]=1.
- Stream 4 PHVs back-to-back with i_ready=1 → 4 consecutive o_valid cycles. Drop i_ready for 3 cycles mid-stream → output held stable, o_ready=0, no PHV lost or duplicated.
- Write ch0 off=0 in the same cycle as accepting a PHV (old off=2) → that result ch0=0x2233; the next PHV gives ch0=0x0011.
- Assert reset while o_valid=1 and held → outputs 0 immediately. After release, config is cleared (a new PHV yields all-zero fields). Write to ch=1 with NUM_CH=1 build → ignored.
